// File: rtl/a2d_sched_if.sv
// Signal bundle between the A2D round-robin scheduler, its trigger source,
// the shared SPI master and the result consumers.
interface a2d_sched_if;
  logic        nxt;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] steer_pot;
  logic [11:0] batt;
  logic        rnd_vld;
  logic        busy;
  logic        ovr;

  modport master (
    input  nxt, done, rd_data,
    output wrt, cmd, lft_ld, rght_ld, steer_pot, batt, rnd_vld, busy, ovr
  );

  modport slave (
    output nxt, done, rd_data,
    input  wrt, cmd, lft_ld, rght_ld, steer_pot, batt, rnd_vld, busy, ovr
  );
endinterface

// File: rtl/a2d_sched.sv
// Round-robin ADC128S conversion scheduler: ch0, ch4, ch5 and (every
// BATT_DIV rounds) ch6, two SPI transactions per channel, latest results held.
module a2d_sched #(
  parameter int unsigned BATT_DIV = 8,
  parameter int unsigned GAP_CYC  = 4
) (
  input  logic         clk,
  input  logic         rst,
  a2d_sched_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, SEND, SEND_WT, GAP1, READ, READ_WT, GAP2, END
  } state_t;

  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYC - 1);
  localparam logic [7:0] BATT_LAST = 8'(BATT_DIV - 1);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_slot, w_slot_nxt;
  logic [3:0]  r_gap;
  logic [7:0]  r_batt_cnt;
  logic        r_pend, w_pend_nxt;
  logic        r_ovr, w_ovr_nxt;
  logic [11:0] r_lft, r_rght, r_steer, r_batt;
  logic [2:0]  w_chnl;
  logic        w_last;
  logic        w_gap_done;
  logic        w_in_gap;
  logic        w_unused;

  // Slot 3 (battery) only exists on rounds where batt_cnt has wrapped to zero.
  always_comb begin
    w_chnl = 3'd6;
    case (r_slot)
      2'd0:    w_chnl = 3'd0;
      2'd1:    w_chnl = 3'd4;
      2'd2:    w_chnl = 3'd5;
      default: w_chnl = 3'd6;
    endcase
  end

  assign w_last     = (r_slot == 2'd3) || ((r_slot == 2'd2) && (r_batt_cnt != '0));
  assign w_in_gap   = (r_state == GAP1) || (r_state == GAP2);
  assign w_gap_done = w_in_gap && (r_gap == GAP_LAST);
  assign w_unused   = ^bus.rd_data[15:12];

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_pend_nxt  = r_pend;
    w_ovr_nxt   = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.nxt || r_pend) begin
          w_state_nxt = SEND;
          w_slot_nxt  = '0;
        end
      end
      SEND:    w_state_nxt = SEND_WT;
      SEND_WT: if (bus.done) w_state_nxt = GAP1;
      GAP1:    if (w_gap_done) w_state_nxt = READ;
      READ:    w_state_nxt = READ_WT;
      READ_WT: if (bus.done) w_state_nxt = w_last ? END : GAP2;
      GAP2: begin
        if (w_gap_done) begin
          w_state_nxt = SEND;
          w_slot_nxt  = r_slot + 2'd1;
        end
      end
      END:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // In IDLE a held trigger is consumed; a trigger arriving that same cycle replaces it.
    if (r_state == IDLE) begin
      if (r_pend) w_pend_nxt = bus.nxt;
    end else if (bus.nxt) begin
      if (r_pend) w_ovr_nxt  = 1'b1;
      else        w_pend_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_slot     <= '0;
      r_gap      <= '0;
      r_batt_cnt <= '0;
      r_pend     <= 1'b0;
      r_ovr      <= 1'b0;
      r_lft      <= '0;
      r_rght     <= '0;
      r_steer    <= 12'h800;
      r_batt     <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
      r_pend  <= w_pend_nxt;
      r_ovr   <= w_ovr_nxt;
      r_gap   <= (w_in_gap && !w_gap_done) ? r_gap + 4'd1 : '0;

      if (r_state == END)
        r_batt_cnt <= (r_batt_cnt == BATT_LAST) ? '0 : r_batt_cnt + 8'd1;

      if ((r_state == READ_WT) && bus.done) begin
        case (r_slot)
          2'd0:    r_lft   <= bus.rd_data[11:0];
          2'd1:    r_rght  <= bus.rd_data[11:0];
          2'd2:    r_steer <= bus.rd_data[11:0];
          default: r_batt  <= bus.rd_data[11:0];
        endcase
      end
    end
  end

  assign bus.wrt       = (r_state == SEND) || (r_state == READ);
  assign bus.cmd       = ((r_state == IDLE) || (r_state == END)) ? '0 : {2'b00, w_chnl, 11'h000};
  assign bus.rnd_vld   = (r_state == END);
  assign bus.busy      = (r_state != IDLE);
  assign bus.ovr       = r_ovr;
  assign bus.lft_ld    = r_lft;
  assign bus.rght_ld   = r_rght;
  assign bus.steer_pot = r_steer;
  assign bus.batt      = r_batt;

endmodule

// File: tb/tb_a2d_sched.sv
// Directed bench for a2d_sched with a behavioural ADC128S/SPI responder.
module tb_a2d_sched;

  localparam int unsigned T_SPI = 5;
  localparam int unsigned RND4  = 8 * (1 + T_SPI) + 7 * 4 + 1;  // 77
  localparam int unsigned RND3  = 6 * (1 + T_SPI) + 5 * 4 + 1;  // 57

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  a2d_sched_if u_if();

  a2d_sched #(.BATT_DIV(8), .GAP_CYC(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  // ADC values indexed by slot: ch0, ch4, ch5, ch6
  logic [11:0] adc_val [4];
  logic        m_done = 1'b0;
  logic [15:0] m_rd   = 16'h0000;
  logic [3:0]  m_cnt  = 4'd0;
  logic [2:0]  m_ch   = 3'd0;
  logic        stray  = 1'b0;

  assign u_if.done    = m_done | stray;
  assign u_if.rd_data = stray ? 16'h0ABC : m_rd;

  function automatic logic [11:0] chan_val(input logic [2:0] ch);
    case (ch)
      3'd0:    return adc_val[0];
      3'd4:    return adc_val[1];
      3'd5:    return adc_val[2];
      3'd6:    return adc_val[3];
      default: return 12'hBAD;
    endcase
  endfunction

  // done arrives T_SPI cycles after the wrt cycle; upper nibble is junk
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (u_if.wrt) begin
      m_cnt <= 4'(T_SPI - 1);
      m_ch  <= u_if.cmd[13:11];
    end else if (m_cnt != 4'd0) begin
      m_cnt <= m_cnt - 4'd1;
      if (m_cnt == 4'd1) begin
        m_done <= 1'b1;
        m_rd   <= {4'hA, chan_val(m_ch)};
      end
    end
  end

  int unsigned wrt_tot  = 0;
  int unsigned busy_tot = 0;
  int unsigned ovr_tot  = 0;
  logic [15:0] cmd_log [512];

  always @(negedge clk) begin
    if (u_if.wrt) begin
      cmd_log[wrt_tot[8:0]] = u_if.cmd;
      wrt_tot = wrt_tot + 1;
    end
    if (u_if.busy) busy_tot = busy_tot + 1;
    if (u_if.ovr)  ovr_tot  = ovr_tot + 1;
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_nxt();
    u_if.nxt = 1'b1;
    step();
    u_if.nxt = 1'b0;
  endtask

  task automatic wait_round(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (u_if.rnd_vld) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk(tag, 16'(ok), 16'd1);
  endtask

  task automatic run_round(input int unsigned ew, input int unsigned eb);
    int unsigned wb, bb;
    wb = wrt_tot;
    bb = busy_tot;
    pulse_nxt();
    chk("start_wrt", 16'(u_if.wrt), 16'd1);
    chk("start_cmd", u_if.cmd, 16'h0000);
    wait_round("rnd_tmo");
    chk("rnd_wrt", 16'(wrt_tot - wb), 16'(ew));
    chk("rnd_len", 16'(busy_tot - bb), 16'(eb));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wrt"},   16'(u_if.wrt),       16'd0);
    chk({tag, "_cmd"},   u_if.cmd,            16'h0000);
    chk({tag, "_busy"},  16'(u_if.busy),      16'd0);
    chk({tag, "_vld"},   16'(u_if.rnd_vld),   16'd0);
    chk({tag, "_ovr"},   16'(u_if.ovr),       16'd0);
    chk({tag, "_lft"},   16'(u_if.lft_ld),    16'h000);
    chk({tag, "_rght"},  16'(u_if.rght_ld),   16'h000);
    chk({tag, "_steer"}, 16'(u_if.steer_pot), 16'h800);
    chk({tag, "_batt"},  16'(u_if.batt),      16'hFFF);
  endtask

  logic [15:0] exp_cmd [8];

  initial begin
    int unsigned base, wb, bb, ob;
    exp_cmd = '{16'h0000, 16'h0000, 16'h2000, 16'h2000,
                16'h2800, 16'h2800, 16'h3000, 16'h3000};
    adc_val = '{12'h400, 12'h3A0, 12'h7FF, 12'hC00};
    u_if.nxt = 1'b0;

    // reset, with a trigger held during reset
    rst = 1'b1;
    u_if.nxt = 1'b1;
    repeat (3) step();
    u_if.nxt = 1'b0;
    chk_reset_vals("rst");
    rst = 1'b0;
    repeat (3) step();
    chk("rst_nxt_ign", 16'(u_if.busy), 16'd0);

    // round 1: basic four-channel round
    base = wrt_tot;
    run_round(8, RND4);
    for (int i = 0; i < 8; i++)
      chk("cmd_seq", cmd_log[9'(base + 32'(i))], exp_cmd[i]);
    chk("r1_lft",   16'(u_if.lft_ld),    16'h400);
    chk("r1_rght",  16'(u_if.rght_ld),   16'h3A0);
    chk("r1_steer", 16'(u_if.steer_pot), 16'h7FF);
    chk("r1_batt",  16'(u_if.batt),      16'hC00);

    // rounds 2..9: battery divider
    adc_val[3] = 12'h900;
    for (int r = 2; r <= 8; r++) begin
      step();
      run_round(6, RND3);
      chk("div_batt_hold", 16'(u_if.batt), 16'hC00);
    end
    step();
    run_round(8, RND4);
    chk("div_batt_new", 16'(u_if.batt), 16'h900);

    // rounds 10..12: steering sweep
    adc_val[2] = 12'h000;
    step();
    run_round(6, RND3);
    chk("sw0_steer", 16'(u_if.steer_pot), 16'h000);
    chk("sw0_lft",   16'(u_if.lft_ld),    16'h400);
    adc_val[2] = 12'hFFF;
    step();
    run_round(6, RND3);
    chk("sw1_steer", 16'(u_if.steer_pot), 16'hFFF);
    chk("sw1_rght",  16'(u_if.rght_ld),   16'h3A0);
    adc_val[2] = 12'h7FF;
    step();
    run_round(6, RND3);
    chk("sw2_steer", 16'(u_if.steer_pot), 16'h7FF);
    chk("sw2_lft",   16'(u_if.lft_ld),    16'h400);

    // rounds 13,14: queued trigger plus one dropped trigger
    step();
    ob = ovr_tot;
    wb = wrt_tot;
    pulse_nxt();
    repeat (10) step();
    pulse_nxt();
    repeat (3) step();
    pulse_nxt();
    wait_round("q_a_tmo");
    chk("q_ovr_once", 16'(ovr_tot - ob), 16'd1);
    step();
    chk("q_idle", 16'(u_if.busy), 16'd0);
    step();
    chk("q_restart", 16'(u_if.wrt), 16'd1);
    wait_round("q_b_tmo");
    chk("q_two_rnds", 16'(wrt_tot - wb), 16'd12);
    repeat (200) step();
    chk("q_no_third", 16'(wrt_tot - wb), 16'd12);
    chk("q_ovr_total", 16'(ovr_tot - ob), 16'd1);

    // rounds 15,16: trigger coincident with END
    wb = wrt_tot;
    pulse_nxt();
    wait_round("c_a_tmo");
    pulse_nxt();
    chk("c_idle", 16'(u_if.busy), 16'd0);
    step();
    chk("c_restart", 16'(u_if.wrt), 16'd1);
    wait_round("c_b_tmo");
    chk("c_two_rnds", 16'(wrt_tot - wb), 16'd12);
    chk("c_no_ovr", 16'(ovr_tot - ob), 16'd1);

    // round 17: stray done in IDLE and in GAP1
    step();
    stray = 1'b1;
    step();
    stray = 1'b0;
    step();
    chk("stray_idle_busy", 16'(u_if.busy),   16'd0);
    chk("stray_idle_lft",  16'(u_if.lft_ld), 16'h400);
    adc_val[0] = 12'h123;
    wb = wrt_tot;
    bb = busy_tot;
    pulse_nxt();
    repeat (7) step();
    stray = 1'b1;
    step();
    stray = 1'b0;
    wait_round("stray_tmo");
    chk("stray_len",   16'(busy_tot - bb),    16'(RND4));
    chk("stray_wrt",   16'(wrt_tot - wb),     16'd8);
    chk("stray_lft",   16'(u_if.lft_ld),      16'h123);
    chk("stray_steer", 16'(u_if.steer_pot),   16'h7FF);

    // round 18: reset during READ_WT of ch4
    step();
    pulse_nxt();
    repeat (32) step();
    rst = 1'b1;
    #1;
    chk_reset_vals("mid");
    step();
    rst = 1'b0;
    repeat (6) step();
    chk("post_rst_lft",  16'(u_if.lft_ld),  16'h000);
    chk("post_rst_rght", 16'(u_if.rght_ld), 16'h000);
    chk("post_rst_busy", 16'(u_if.busy),    16'd0);
    run_round(8, RND4);
    chk("after_rst_rght", 16'(u_if.rght_ld), 16'h3A0);
    chk("after_rst_batt", 16'(u_if.batt),    16'h900);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/a2d_sched.md
# a2d_sched

Round-robin conversion scheduler for the ADC128S A2D channels used by the Segway: left load cell, right load cell, steering pot and battery. On each trigger it sequences the two-transaction ADC128S protocol per channel through the shared SPI master and holds the latest 12-bit result for each channel. It sits between the SPI master driving A2D_SS_n/A2D_SCLK/A2D_MOSI/A2D_MISO and the consumers: the rider-detect logic, the steering logic and the low-battery/piezo logic.

## Interface
- BATT_DIV, 8: battery is converted on one round in every BATT_DIV rounds; legal range 1..255.
- GAP_CYC, 4: idle cycles with wrt low between consecutive SPI transactions, so SS_n deasserts; legal range 1..15.
- clk  input  1  system clock; single clock domain.
- rst  input  1  asynchronous reset, active-high.
- nxt  input  1  one-cycle trigger that starts a conversion round.
- wrt  output  1  one-cycle pulse to the SPI master to start a 16-bit transaction.
- cmd  output  16  SPI command word, {2'b00, chnl[2:0], 11'h000}.
- done  input  1  one-cycle pulse from the SPI master when its transaction is complete.
- rd_data  input  16  SPI read word; bits [11:0] are valid when done is high.
- lft_ld  output  12  latest left load cell result (channel 0).
- rght_ld  output  12  latest right load cell result (channel 4).
- steer_pot  output  12  latest steering pot result (channel 5).
- batt  output  12  latest battery result (channel 6).
- rnd_vld  output  1  one-cycle pulse when a round finishes.
- busy  output  1  high from round start until the cycle of rnd_vld.
- ovr  output  1  one-cycle pulse when a trigger is dropped.

## Operation
- **Round order:** ch0, ch4, ch5, then ch6 only when batt_cnt == 0.
- **batt_cnt:** an 8-bit counter, reset 0. It increments modulo BATT_DIV at the end of every round.
- **Per-channel protocol, in order:**
  - SEND: cmd = the channel's command word. Pulse wrt. Wait for done. The returned data is discarded.
  - GAP: count GAP_CYC cycles.
  - READ: cmd is unchanged. Pulse wrt. Wait for done. Capture rd_data[11:0] into the channel's result register.
  - GAP: count GAP_CYC cycles before the next channel, or skip directly to END after the last channel.
- **States:** IDLE, SEND, SEND_WT, GAP1, READ, READ_WT, GAP2, END.
- **Transitions:**
  - IDLE to SEND on nxt, or on pend set.
  - SEND to SEND_WT after one cycle; wrt is high in SEND.
  - SEND_WT to GAP1 on done.
  - GAP1 to READ when the gap count reaches GAP_CYC.
  - READ to READ_WT; wrt is high in READ.
  - READ_WT to GAP2 on done when another channel remains, or to END on done for the last channel.
  - GAP2 to SEND with the next channel selected.
  - END to IDLE; rnd_vld is pulsed in END.
- **Trigger queue:** one deep.
  - nxt while busy: sets pend.
  - nxt while pend is already set: pulses ovr and drops the trigger.
  - nxt in the same cycle as END: sets pend.
  - Leaving IDLE because of pend clears pend.
- **Result registers:** update only in the cycle after the done that ends a READ. They are otherwise stable, with no partial values.
- **cmd:** held constant from SEND through READ_WT. It reads 16'h0000 in IDLE.
- **done outside a *_WT state:** ignored.
- **nxt during reset:** ignored; pend is not set.

## Timing
- **Reset values:**
  - wrt = 0, cmd = 0, rnd_vld = 0, busy = 0, ovr = 0.
  - lft_ld = 0, rght_ld = 0.
  - steer_pot = 12'h800 (centre).
  - batt = 12'hFFF, so low battery is not flagged before the first conversion.
  - State = IDLE, pend = 0, batt_cnt = 0.
- **Reset assertion mid-round:** all registers return to their reset values immediately. wrt drops the same cycle, asynchronously. A done arriving afterwards is ignored.
- **Start latency:** wrt is high 1 cycle after nxt, in SEND.
- **Result latency:** a channel's result is visible 1 cycle after its READ done.
- **Round length:**
  - 4 channels: 8·(1 + T_spi) + 7·GAP_CYC + 1 cycles.
  - 3 channels: 6·(1 + T_spi) + 5·GAP_CYC + 1 cycles.
  - T_spi is the number of cycles from wrt to done.
- **busy:** rises the cycle after the accepting nxt and falls the cycle after rnd_vld.

## Test plan
- **Basic round:**
  - Stimulus: ADC model set to ld_cell_lft=12'h400, ld_cell_rght=12'h3A0, steerPot=12'h7FF, batt=12'hC00; reset, then a single nxt.
  - Response: cmd sequence 16'h0000, 16'h2000, 16'h2800, 16'h3000, each sent twice, with 8 wrt pulses in total.
  - Response at rnd_vld: lft_ld=12'h400, rght_ld=12'h3A0, steer_pot=12'h7FF, batt=12'hC00.
- **Battery divider:** 9 rounds with BATT_DIV=8.
  - Battery is converted in rounds 1 and 9 only; rounds 2–8 each issue 6 wrt pulses.
  - Changing batt to 12'h900 after round 1 shows on the batt output only after round 9.
- **Reset values and reset mid-round:**
  - Check the reset values: steer_pot=12'h800, batt=12'hFFF, busy=0.
  - Assert rst during READ_WT of ch4: wrt=0 immediately; the outputs show the reset values; the next nxt restarts at cmd=16'h0000.
- **Trigger queueing:**
  - nxt during round 1: round 2 starts within 1 cycle of the round-1 END, with no gap.
  - A third nxt while pend=1: ovr pulses exactly once and no third round runs.
  - nxt coincident with END: pend is set and round 2 runs.
- **Stray done:** a done pulse in IDLE and in GAP1 causes no state change and no register update; the round completes with the correct values.
- **Steering sweep:** steerPot values 12'h000, 12'hFFF, 12'h7FF across consecutive rounds; steer_pot tracks each value one round later, and the load-cell outputs are unchanged.
